// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type, core limit and one-hot helper for mem_arbiter
package mem_arbiter_pkg;
  localparam int MAX_CORES = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  function automatic logic [MAX_CORES-1:0] onehot(input int idx, input int cores);
    return (idx < cores) ? MAX_CORES'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_select.sv
// rr_select: winner index from req, round-robin from ptr (MEM_ARBITER_FIXED_PRIO_EN: lowest index wins)
module rr_select #(
  parameter int CORES = 4,
  parameter int PW = $clog2(CORES)
) (
  input  logic [CORES-1:0] req,
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  input  logic [PW-1:0]    ptr,
`endif
  output logic [PW-1:0]    winner,
  output logic             anyReq
);
  assign anyReq = |req;
  always_comb begin
    winner = '0;
    for (int k = CORES - 1; k >= 0; k--)
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      if (req[k]) winner = PW'(k);
`else
      if (req[(int'(ptr) + k) % CORES]) winner = PW'((int'(ptr) + k) % CORES);
`endif
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises core requests onto one RAM port; MEM_ARBITER_FIXED_PRIO_EN selects fixed priority
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CORES = 4,
  parameter int WIDTH = 12,
  parameter int DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CORES-1:0]            req,
  input  logic [CORES-1:0]            reqWrEn,
  input  logic [CORES*ADDR_WIDTH-1:0] reqAddr,
  input  logic [CORES*WIDTH-1:0]      reqData,
  output logic [CORES-1:0]            grant,
  output logic [CORES-1:0]            rdValid,
  output logic [WIDTH-1:0]            rdData,
  output logic                        memWrEn,
  output logic [ADDR_WIDTH-1:0]       memAddr,
  output logic [WIDTH-1:0]            memDataIn,
  input  logic [WIDTH-1:0]            memDataOut
);
  localparam int PW = $clog2(CORES);
  state_t state, next;
  logic [PW-1:0] owner, winner;
  logic anyReq, load, memWrEnD;
  logic [CORES-1:0] grantD, rdValidD;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  rr_select #(.CORES(CORES), .PW(PW)) sel (.req(req), .winner(winner), .anyReq(anyReq));
`else
  logic [PW-1:0] ptr;
  rr_select #(.CORES(CORES), .PW(PW)) sel (.req(req), .ptr(ptr), .winner(winner), .anyReq(anyReq));
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (load) ptr <= (winner == PW'(CORES - 1)) ? '0 : winner + 1'b1;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb
    next = (state == IDLE) ? (anyReq ? ISSUE : IDLE) :
           (state == ISSUE) ? (memWrEn ? IDLE : RDWAIT) : IDLE;
  always_comb begin
    load = (state == IDLE) && anyReq;
    grantD = load ? CORES'(onehot(int'(winner), CORES)) : '0;
    memWrEnD = load && reqWrEn[winner];
    rdValidD = (state == RDWAIT) ? CORES'(onehot(int'(owner), CORES)) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      grant <= '0;
      rdValid <= '0;
      rdData <= '0;
      memWrEn <= 1'b0;
      memAddr <= '0;
      memDataIn <= '0;
      owner <= '0;
    end else begin
      grant <= grantD;
      rdValid <= rdValidD;
      memWrEn <= memWrEnD;
      if (load) begin
        memAddr <= reqAddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        memDataIn <= reqData[winner*WIDTH +: WIDTH];
        owner <= winner;
      end
      if (state == RDWAIT) rdData <= memDataOut;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter driving a behavioural single-port RAM
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, reqWrEn = '0, grant, rdValid;
  logic [31:0] reqAddr = '0;
  logic [47:0] reqData = '0;
  logic [11:0] rdData, memDataIn, memDataOut;
  logic memWrEn;
  logic [7:0] memAddr;
  logic [11:0] ram [256];
  logic [11:0] model [8];
  logic [3:0] first, second;
  logic [11:0] exp [4];
  int errors = 0, checks = 0;

  mem_arbiter #(.CORES(4), .WIDTH(12), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req(req), .reqWrEn(reqWrEn), .reqAddr(reqAddr), .reqData(reqData),
    .grant(grant), .rdValid(rdValid), .rdData(rdData), .memWrEn(memWrEn), .memAddr(memAddr),
    .memDataIn(memDataIn), .memDataOut(memDataOut));

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (memWrEn) ram[memAddr] <= memDataIn;
    memDataOut <= ram[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setCore(input int c, input logic we, input logic [7:0] a, input logic [11:0] d);
    reqWrEn[c] = we;
    reqAddr[c*8 +: 8] = a;
    reqData[c*12 +: 12] = d;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_rdValid"}, 32'(rdValid), 0);
    chk({tag, "_rdData"}, 32'(rdData), 0);
    chk({tag, "_memWrEn"}, 32'(memWrEn), 0);
    chk({tag, "_memAddr"}, 32'(memAddr), 0);
    chk({tag, "_memDataIn"}, 32'(memDataIn), 0);
  endtask

  task automatic access(input int c, input logic we, input logic [7:0] a, input logic [11:0] d);
    setCore(c, we, a, d);
    req = 4'(1 << c);
    tick;
    chk("grant", 32'(grant), 32'(1 << c));
    chk("memWrEn", 32'(memWrEn), 32'(we));
    chk("memAddr", 32'(memAddr), 32'(a));
    if (we) chk("memDataIn", 32'(memDataIn), 32'(d));
    req = '0;
    tick;
    chk("grant_pulse", 32'(grant), 0);
    chk("memWrEn_pulse", 32'(memWrEn), 0);
    if (we) chk("ram_write", 32'(ram[a]), 32'(d));
    else begin
      chk("rdValid_early", 32'(rdValid), 0);
      tick;
      chk("rdValid", 32'(rdValid), 32'(1 << c));
      chk("rdData", 32'(rdData), 32'(d));
    end
    tick;
    chk("rdValid_pulse", 32'(rdValid), 0);
  endtask

  initial begin
    tick;
    tick;
    chkIdle("reset");
    rst = 1'b0;
    access(1, 1'b1, 8'd3, 12'd100);
    access(2, 1'b0, 8'd3, 12'd100);
    access(3, 1'b1, 8'd20, 12'h123);
    exp[0] = 12'd100;
    exp[1] = 12'h123;
    exp[2] = 12'd100;
    exp[3] = 12'h123;
    setCore(0, 1'b0, 8'd3, 12'h0);
    setCore(1, 1'b0, 8'd20, 12'h0);
    setCore(2, 1'b0, 8'd3, 12'h0);
    setCore(3, 1'b0, 8'd20, 12'h0);
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("all_grant", 32'(grant), 32'(1 << k));
      req[k] = 1'b0;
      tick;
      chk("all_grant_pulse", 32'(grant), 0);
      tick;
      chk("all_rdValid", 32'(rdValid), 32'(1 << k));
      chk("all_rdData", 32'(rdData), 32'(exp[k]));
    end
    tick;
    chk("all_rdValid_end", 32'(rdValid), 0);
    access(2, 1'b1, 8'd30, 12'h7FF);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    first = 4'b0001;
    second = 4'b1000;
`else
    first = 4'b1000;
    second = 4'b0001;
`endif
    setCore(0, 1'b1, 8'd41, 12'h444);
    setCore(3, 1'b1, 8'd40, 12'h333);
    req = 4'b1001;
    tick;
    chk("wrap_first", 32'(grant), 32'(first));
    req = second;
    tick;
    chk("wrap_gap", 32'(grant), 0);
    tick;
    chk("wrap_second", 32'(grant), 32'(second));
    req = '0;
    tick;
    tick;
    chk("wrap_ram40", 32'(ram[40]), 32'h333);
    chk("wrap_ram41", 32'(ram[41]), 32'h444);
    setCore(0, 1'b0, 8'd20, 12'h0);
    req = 4'b0001;
    tick;
    chk("rst_grant", 32'(grant), 32'b0001);
    req = '0;
    tick;
    rst = 1'b1;
    tick;
    chkIdle("midrst");
    rst = 1'b0;
    tick;
    chk("midrst_rdValid", 32'(rdValid), 0);
    tick;
    chk("midrst_rdValid2", 32'(rdValid), 0);
    access(0, 1'b0, 8'd3, 12'd100);
    for (int a = 0; a < 8; a++) begin
      model[a] = 12'($urandom);
      access(int'($urandom_range(0, 3)), 1'b1, 8'(50 + a), model[a]);
    end
    for (int n = 0; n < 30; n++) begin
      int c, a;
      c = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        model[a] = 12'($urandom);
        access(c, 1'b1, 8'(50 + a), model[a]);
      end else access(c, 1'b0, 8'(50 + a), model[a]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
